// File: rtl/ff_excitation_encoder.sv
// rtl/ff_excitation_encoder.sv - derives SR/JK/D/T excitations for a target state,
// applies them to an internal flip-flop bank and self-checks the result.
module ff_excitation_encoder #(
  parameter int WIDTH   = 4,
  parameter int DC_FILL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [1:0]       in_mode,
  output logic [WIDTH-1:0] exc_a,
  output logic [WIDTH-1:0] exc_b,
  output logic             exc_valid,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             mismatch,
  output logic             err,
  output logic [15:0]      txn_count
);

  typedef enum logic [1:0] {IDLE, ENCODE, APPLY, CHECK} state_t;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic       DC      = (DC_FILL != 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] enc_a, enc_b, q_next, dc_vec;
  logic             accept;

  assign dc_vec = {WIDTH{DC}};
  assign accept = (state_q == IDLE) && in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ENCODE;
      ENCODE:  state_d = APPLY;
      APPLY:   state_d = CHECK;
      default: state_d = IDLE;
    endcase
  end

  // SR don't-cares sit on opposite target values, so s and r can never both be 1.
  always_comb begin
    enc_a = '0;
    enc_b = '0;
    case (in_mode)
      MODE_SR: begin
        enc_a = in_target & (~q | dc_vec);
        enc_b = ~in_target & (q | dc_vec);
      end
      MODE_JK: begin
        enc_a = (~q & in_target) | (q & dc_vec);
        enc_b = (q & ~in_target) | (~q & dc_vec);
      end
      MODE_D:  enc_a = in_target;
      default: enc_a = q ^ in_target;
    endcase
  end

  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode_q)
        MODE_SR: q_next[i] = (exc_a[i] & exc_b[i]) ? 1'bx : (exc_a[i] | (~exc_b[i] & q[i]));
        MODE_JK: q_next[i] = (exc_a[i] & ~q[i]) | (~exc_b[i] & q[i]);
        MODE_D:  q_next[i] = exc_a[i];
        default: q_next[i] = exc_a[i] ^ q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      q         <= '0;
      exc_a     <= '0;
      exc_b     <= '0;
      exc_valid <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err       <= 1'b0;
      txn_count <= '0;
      target_q  <= '0;
      mode_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      exc_valid <= accept;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      if (accept) begin
        target_q <= in_target;
        mode_q   <= in_mode;
        exc_a    <= enc_a;
        exc_b    <= enc_b;
      end
      if (state_q == APPLY) begin
        q         <= q_next;
        done      <= 1'b1;
        mismatch  <= (q_next != target_q);
        err       <= err | (q_next != target_q);
        txn_count <= txn_count + 16'd1;
      end
    end
  end

  a_no_sr_conflict: assert property (@(posedge clk) disable iff (rst)
    (state_q == APPLY && mode_q == MODE_SR) |-> ((exc_a & exc_b) == '0));

endmodule

// File: tb/tb_ff_excitation_encoder.sv
// tb/tb_ff_excitation_encoder.sv - random and directed checks of ff_excitation_encoder
module tb_ff_excitation_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_target = '0;
  logic [1:0] in_mode = '0;

  logic        in_ready [2];
  logic        exc_valid[2];
  logic        done     [2];
  logic        mismatch [2];
  logic        err      [2];
  logic [3:0]  exc_a    [2];
  logic [3:0]  exc_b    [2];
  logic [3:0]  q        [2];
  logic [15:0] txn_count[2];

  int errors = 0;
  int checks = 0;
  logic [3:0] q_model = '0;
  int count_model = 0;

  always #5 clk = ~clk;

  ff_excitation_encoder #(.WIDTH(4), .DC_FILL(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_target(in_target), .in_mode(in_mode), .exc_a(exc_a[0]), .exc_b(exc_b[0]),
    .exc_valid(exc_valid[0]), .q(q[0]), .done(done[0]), .mismatch(mismatch[0]),
    .err(err[0]), .txn_count(txn_count[0])
  );

  ff_excitation_encoder #(.WIDTH(4), .DC_FILL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_target(in_target), .in_mode(in_mode), .exc_a(exc_a[1]), .exc_b(exc_b[1]),
    .exc_valid(exc_valid[1]), .q(q[1]), .done(done[1]), .mismatch(mismatch[1]),
    .err(err[1]), .txn_count(txn_count[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Excitation table lookup, one bit at a time, straight from the flip-flop tables.
  function automatic void model_exc(input logic [3:0] cur, input logic [3:0] tgt,
                                    input logic [1:0] md, input logic dc,
                                    output logic [3:0] a, output logic [3:0] b);
    for (int i = 0; i < 4; i++) begin
      case (md)
        2'd0: case ({cur[i], tgt[i]})
          2'b00: {a[i], b[i]} = {1'b0, dc};
          2'b01: {a[i], b[i]} = 2'b10;
          2'b10: {a[i], b[i]} = 2'b01;
          default: {a[i], b[i]} = {dc, 1'b0};
        endcase
        2'd1: case ({cur[i], tgt[i]})
          2'b00: {a[i], b[i]} = {1'b0, dc};
          2'b01: {a[i], b[i]} = {1'b1, dc};
          2'b10: {a[i], b[i]} = {dc, 1'b1};
          default: {a[i], b[i]} = {dc, 1'b0};
        endcase
        2'd2: {a[i], b[i]} = {tgt[i], 1'b0};
        default: {a[i], b[i]} = {(cur[i] != tgt[i]), 1'b0};
      endcase
    end
  endfunction

  task automatic check_ctl(input string ph, input logic rdy, input logic ev,
                           input logic dn, input logic [3:0] qe);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.in_ready%0d", ph, k), in_ready[k], rdy);
      check($sformatf("%s.exc_valid%0d", ph, k), exc_valid[k], ev);
      check($sformatf("%s.done%0d", ph, k), done[k], dn);
      check($sformatf("%s.q%0d", ph, k), q[k], qe);
      check($sformatf("%s.txn_count%0d", ph, k), txn_count[k], 16'(count_model));
      check($sformatf("%s.err%0d", ph, k), err[k], 1'b0);
    end
  endtask

  task automatic check_exc(input string ph, input logic [3:0] ea0, input logic [3:0] eb0,
                           input logic [3:0] ea1, input logic [3:0] eb1);
    check({ph, ".exc_a0"}, exc_a[0], ea0);
    check({ph, ".exc_b0"}, exc_b[0], eb0);
    check({ph, ".exc_a1"}, exc_a[1], ea1);
    check({ph, ".exc_b1"}, exc_b[1], eb1);
  endtask

  // Entered and left at a negedge with both DUTs idle.
  task automatic run_txn(input logic [3:0] tgt, input logic [1:0] md);
    logic [3:0] ea0, eb0, ea1, eb1;
    model_exc(q_model, tgt, md, 1'b0, ea0, eb0);
    model_exc(q_model, tgt, md, 1'b1, ea1, eb1);
    in_valid = 1'b1;
    in_target = tgt;
    in_mode = md;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_target = 4'($urandom);
    in_mode = 2'($urandom);
    @(negedge clk);
    check_ctl("encode", 1'b0, 1'b1, 1'b0, q_model);
    check_exc("encode", ea0, eb0, ea1, eb1);
    if (md == 2'd0)
      for (int k = 0; k < 2; k++) check($sformatf("sr_conflict%0d", k), exc_a[k] & exc_b[k], 4'b0000);
    @(negedge clk);
    check_ctl("apply", 1'b0, 1'b0, 1'b0, q_model);
    @(negedge clk);
    count_model++;
    check_ctl("check", 1'b0, 1'b0, 1'b1, tgt);
    check_exc("check", ea0, eb0, ea1, eb1);
    for (int k = 0; k < 2; k++) check($sformatf("check.mismatch%0d", k), mismatch[k], 1'b0);
    @(negedge clk);
    check_ctl("idle", 1'b1, 1'b0, 1'b0, tgt);
    q_model = tgt;
  endtask

  initial begin
    logic [3:0] tgt;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_ctl("reset", 1'b1, 1'b0, 1'b0, 4'b0000);
    check_exc("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 2; k++) check($sformatf("reset.mismatch%0d", k), mismatch[k], 1'b0);
    rst = 1'b0;

    // Reset during APPLY aborts the transaction
    in_valid = 1'b1;
    in_target = 4'b1001;
    in_mode = 2'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_ctl("abort", 1'b1, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    check_ctl("abort_next", 1'b1, 1'b0, 1'b0, 4'b0000);

    // Directed sequence
    run_txn(4'b1010, 2'd0);
    run_txn(4'b0110, 2'd1);
    run_txn(4'b0101, 2'd3);
    run_txn(4'b1111, 2'd2);
    run_txn(4'b0101, 2'd0);
    run_txn(4'b0101, 2'd0);
    run_txn(4'b0101, 2'd1);

    // Random transactions across all modes
    for (int n = 0; n < 24; n++) run_txn(4'($urandom), 2'($urandom));

    // in_valid held high: one acceptance every fourth cycle
    tgt = 4'($urandom);
    in_valid = 1'b1;
    in_target = tgt;
    in_mode = 2'd2;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy%0d.in_ready%0d", i, k), in_ready[k], (i % 4 == 0));
        check($sformatf("busy%0d.exc_valid%0d", i, k), exc_valid[k], (i % 4 == 1));
        check($sformatf("busy%0d.done%0d", i, k), done[k], (i % 4 == 3));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    count_model += 3;
    q_model = tgt;
    @(negedge clk);
    check_ctl("busy_end", 1'b1, 1'b0, 1'b0, q_model);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
